// File: rtl/regbank_pkg.sv
// Shared types and defaults for the register-bank write controller.
// Imported by the arbiter and the top level.
package regbank_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREGS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with a one-hot grant.
// The grant history only moves on a completed transfer (advance_i).
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  port_t last_grant_q, last_grant_d;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_q == PORT0) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
    if (advance_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_o[1] ? PORT1 : PORT0;
    end
  end

  // Resetting to PORT1 lets port 0 win the first contention.
  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/regbank_write_ctrl.sv
// Write-port controller for an NREGS x WIDTH register bank: arbitrates two
// writers, sequences one-cycle load strobes, and provides a registered read port.
module regbank_write_ctrl
  import regbank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  input  logic [$clog2(NREGS)-1:0]  req0_addr,
  input  logic [WIDTH-1:0]          req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [$clog2(NREGS)-1:0]  req1_addr,
  input  logic [WIDTH-1:0]          req1_data,
  output logic                      req1_ready,
  input  logic [$clog2(NREGS)-1:0]  rd_addr,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      busy
);

  localparam int ADDR_W = $clog2(NREGS);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0]   pend_data_q, pend_data_d;
  logic [WIDTH-1:0]   bank_q [NREGS];
  logic [WIDTH-1:0]   rd_data_q, rd_mux;
  logic [NREGS-1:0]   load_vec;
  logic [1:0]         grant;
  logic               advance;

  assign advance = (state_q == IDLE) && (req0_valid || req1_valid);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({req1_valid, req0_valid}),
    .advance_i (advance),
    .grant_o   (grant)
  );

  // Ready is only offered from IDLE; grant is already qualified by valid.
  assign req0_ready = (state_q == IDLE) && grant[0];
  assign req1_ready = (state_q == IDLE) && grant[1];
  assign busy       = (state_q == LOAD);
  assign rd_data    = rd_data_q;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    case (state_q)
      IDLE: begin
        if (advance) begin
          state_d     = LOAD;
          pend_addr_d = grant[1] ? req1_addr : req0_addr;
          pend_data_d = grant[1] ? req1_data : req0_data;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range pending addresses match no strobe, so the LOAD cycle is spent with no commit.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      load_vec[i] = (state_q == LOAD) && (pend_addr_q == ADDR_W'(i));
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_mux = bank_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rd_data_q   <= rd_mux;
    end
  end

  // NOTE: the bank is built from flops, not a RAM macro, so it can and must clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) bank_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (load_vec[i]) bank_q[i] <= pend_data_q;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_ctrl.sv
// Directed bench for regbank_write_ctrl: an 8-register instance for the main
// scenarios and a 6-register instance for out-of-range addressing.
module tb_regbank_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;

  logic        req0_valid, req1_valid, req0_ready, req1_ready, busy;
  logic [2:0]  req0_addr, req1_addr, rd_addr;
  logic [15:0] req0_data, req1_data, rd_data;

  logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready, b_busy;
  logic [2:0]  b_req0_addr, b_req1_addr, b_rd_addr;
  logic [15:0] b_req0_data, b_req1_data, b_rd_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regbank_write_ctrl #(.WIDTH(16), .NREGS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy)
  );

  regbank_write_ctrl #(.WIDTH(16), .NREGS(6)) dut6 (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (b_req0_valid),
    .req0_addr  (b_req0_addr),
    .req0_data  (b_req0_data),
    .req0_ready (b_req0_ready),
    .req1_valid (b_req1_valid),
    .req1_addr  (b_req1_addr),
    .req1_data  (b_req1_data),
    .req1_ready (b_req1_ready),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .busy       (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 2 time units after a rising edge; outputs are read 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    rd_addr = 0;
    b_req0_valid = 0; b_req0_addr = 0; b_req0_data = 0;
    b_req1_valid = 0; b_req1_addr = 0; b_req1_data = 0;
    b_rd_addr = 0;

    repeat (2) tick();
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_rd",     32'(rd_data),    32'd0);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      tick(); #1;
      check("rd_after_reset", 32'(rd_data), 32'd0);
    end

    // Reset while a write of 1234 to r3 is in LOAD
    req0_valid = 1; req0_addr = 3; req0_data = 16'h1234;
    #1 check("r3_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    #1 check("r3_load_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1 check("r3_reset_idle", 32'(busy), 32'd0);
    reset = 1'b0;
    rd_addr = 3;
    tick(); tick(); #1;
    check("r3_not_written", 32'(rd_data), 32'd0);
    check("r3_idle_after",  32'(busy),    32'd0);

    // Single write by port 0: r2 <- 1234
    req0_valid = 1; req0_addr = 2; req0_data = 16'h1234; rd_addr = 2;
    #1;
    check("w_ready0", 32'(req0_ready), 32'd1);
    check("w_ready1", 32'(req1_ready), 32'd0);
    check("w_busy0",  32'(busy),       32'd0);
    tick();
    req0_valid = 0;
    #1;
    check("w_busy_load", 32'(busy),       32'd1);
    check("w_ready_load",32'(req0_ready), 32'd0);
    check("w_rd_n",      32'(rd_data),    32'd0);
    tick(); #1;
    check("w_busy_n1",   32'(busy),       32'd0);
    check("w_rd_n1",     32'(rd_data),    32'd0);
    tick(); #1;
    check("w_rd_n2",     32'(rd_data),    32'h1234);

    // Fresh reset so the first contention goes to port 0
    reset = 1'b1;
    #1 reset = 1'b0;

    // Contention on r1: p0 <- AAAA, p1 <- 5555
    req0_valid = 1; req0_addr = 1; req0_data = 16'hAAAA;
    req1_valid = 1; req1_addr = 1; req1_data = 16'h5555;
    rd_addr = 1;
    #1;
    check("c_grant0_r0", 32'(req0_ready), 32'd1);
    check("c_grant0_r1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0;
    #1;
    check("c_load1_busy", 32'(busy),       32'd1);
    check("c_load1_r1",   32'(req1_ready), 32'd0);
    tick(); #1;
    check("c_grant1_r1", 32'(req1_ready), 32'd1);
    check("c_grant1_r0", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 0;
    #1;
    check("c_load2_busy", 32'(busy),    32'd1);
    check("c_rd_aaaa",    32'(rd_data), 32'hAAAA);
    tick(); #1;
    check("c_rd_old",     32'(rd_data), 32'hAAAA);
    check("c_idle",       32'(busy),    32'd0);
    tick(); #1;
    check("c_rd_final",   32'(rd_data), 32'h5555);

    // Port 1 alone twice; last grant was port 1
    req1_valid = 1; req1_addr = 4; req1_data = 16'hFFFF;
    #1;
    check("p1a_ready1", 32'(req1_ready), 32'd1);
    check("p1a_ready0", 32'(req0_ready), 32'd0);
    tick();
    req1_addr = 5; req1_data = 16'h0000;
    #1;
    check("p1a_load_ready", 32'(req1_ready), 32'd0);
    check("p1a_load_busy",  32'(busy),       32'd1);
    tick(); #1;
    check("p1b_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 0; rd_addr = 4;
    #1 check("p1b_busy", 32'(busy), 32'd1);
    tick(); #1;
    check("p1_rd_r4", 32'(rd_data), 32'hFFFF);
    rd_addr = 5;
    tick(); tick(); #1;
    check("p1_rd_r5", 32'(rd_data), 32'h0000);

    // Read of r6 in the same cycle it commits BEEF over 0001
    req0_valid = 1; req0_addr = 6; req0_data = 16'h0001;
    tick();
    req0_valid = 0;
    tick();
    rd_addr = 6;
    req0_valid = 1; req0_addr = 6; req0_data = 16'hBEEF;
    tick();
    req0_valid = 0;
    #1 check("byp_before", 32'(rd_data), 32'h0001);
    tick(); #1;
    check("byp_commit_cycle", 32'(rd_data), 32'h0001);
    tick(); #1;
    check("byp_after", 32'(rd_data), 32'hBEEF);

    // NREGS = 6: write to addr 7 is accepted but changes nothing
    b_req0_valid = 1; b_req0_addr = 7; b_req0_data = 16'h1234;
    #1 check("oor_ready0", 32'(b_req0_ready), 32'd1);
    tick();
    b_req0_valid = 0;
    #1 check("oor_busy", 32'(b_busy), 32'd1);
    tick(); #1;
    check("oor_idle", 32'(b_busy), 32'd0);
    for (int a = 0; a < 8; a++) begin
      b_rd_addr = 3'(a);
      tick(); #1;
      check("oor_rd", 32'(b_rd_data), 32'd0);
    end

    b_req0_valid = 1; b_req0_addr = 5; b_req0_data = 16'h5A5A; b_rd_addr = 5;
    tick();
    b_req0_valid = 0;
    tick(); tick(); #1;
    check("n6_rd_r5", 32'(b_rd_data), 32'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_write_ctrl.md
# regbank_write_ctrl

Write-port controller for the CPU's bank of `NREGS` 16-bit registers. Two requesters, the core writeback (port 0) and the debug/loader port (port 1), share the single write path through a round-robin arbiter with a valid/ready handshake. The controller sequences the per-register `load` strobes and provides a registered read port. It sits between the core control unit and the register storage.

## Interface
- `WIDTH`, 16: data width of each register.
- `NREGS`, 8: number of registers. Legal range is 2..16.
- `ADDR_W`, `$clog2(NREGS)`: address width. Derived; do not override.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `req0_valid`  in  1: port 0 write request.
- `req0_addr`  in  `ADDR_W`: port 0 target register.
- `req0_data`  in  `WIDTH`: port 0 write data.
- `req0_ready`  out  1: port 0 request accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as port 0, for port 1.
- `rd_addr`  in  `ADDR_W`: read address.
- `rd_data`  out  `WIDTH`: registered read data.
- `busy`  out  1: high while in LOAD.

## Operation
- Storage is `NREGS` × `WIDTH` registers. Every register resets to 0.
- The FSM has two states, IDLE and LOAD. Reset state is IDLE.
- IDLE:
  - If any `reqN_valid` is high, the arbiter picks a winner.
  - The controller raises `reqN_ready` for the winner only (combinational, same cycle).
  - It captures the winner's addr/data into the pending registers and moves to LOAD.
- LOAD:
  - Asserts the load strobe of the pending register for exactly one cycle.
  - The register takes the pending data at the edge that ends LOAD.
  - Returns to IDLE.
  - Both `ready` outputs are low during LOAD.
- Handshake:
  - A transfer occurs when `valid && ready` are both high at a rising edge.
  - A requester must hold valid, addr and data stable until ready.
  - Ready never asserts without valid.
- Arbitration:
  - The `last_grant` flop resets to 1, so port 0 wins the first contention.
  - On simultaneous requests, the port not granted last wins.
  - A lone request always wins, regardless of `last_grant`.
  - `last_grant` updates only on a transfer.
- Throughput is at most one write per 2 cycles. Sustained contention alternates strictly 0, 1, 0, 1.
- Address out of range (`addr >= NREGS`, possible only when `NREGS` is not a power of 2):
  - The request is still accepted and consumes a LOAD cycle.
  - No register changes.
- Read port:
  - `rd_data <= bank[rd_addr]` each cycle. Out-of-range reads return 0.
  - There is no write bypass. A read of a register in the same cycle as its LOAD commit returns the old value.

## Timing
- Reset values:
  - `req0_ready`, `req1_ready`, `busy`: 0.
  - `rd_data`: 0.
  - All bank registers: 0.
  - Pending addr/data: 0.
  - `last_grant`: 1.
- Write latency:
  - Handshake at edge N.
  - LOAD during cycle N to N+1.
  - New value on the register output after edge N+1.
  - `rd_data` shows it after edge N+2 when `rd_addr` is held.
- Read latency: 1 cycle.
- Reset asserted mid-operation (including during LOAD):
  - The FSM immediately returns to IDLE and all state clears.
  - The pending write is lost.
  - Nothing is committed after reset deasserts.
- `busy` equals "state == LOAD".

## Structure
- Package `regbank_pkg` holds:
  - `WIDTH` and `NREGS` defaults.
  - The `state_t` enum (IDLE, LOAD).
  - The `port_t` grant type (PORT0, PORT1).
- Sub-module `rr_arbiter2` holds:
  - 2-request round-robin, one-hot grant output.
  - The `last_grant` flop and an `advance` input tied to "transfer occurred".
- The top level holds the FSM, the pending registers, the load-strobe decoder, the storage array and the read register.

## Test plan
- Reset, then read every address: `rd_data` = 0 for all addresses. Assert `reset` during LOAD of a write of 16'h1234 to r3: r3 stays 0 and the FSM is IDLE.
- Port 0 writes 16'h1234 to r2 at edge N, `rd_addr` = 2: `req0_ready` is high for 1 cycle, `busy` is high N to N+1, and `rd_data` = 16'h1234 after edge N+2.
- Both ports valid every cycle (p0: r1 ← 16'hAAAA, p1: r1 ← 16'h5555): grants are p0 then p1. Final r1 = 16'h5555, and `ready` never asserts during LOAD.
- Port 1 requests alone twice in a row (r4 ← 16'hFFFF, then r5 ← 16'h0000): both are granted without waiting for port 0, at 2-cycle spacing.
- `rd_addr` = 6 in the same cycle r6 commits 16'hBEEF over 16'h0001: that cycle's `rd_data` = 16'h0001, and the next is 16'hBEEF.
- `NREGS` = 6, write to addr 7: the request is accepted, a LOAD cycle is used, no register changes, and a read of addr 7 returns 0.
